// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared state encoding, sync word and config sizing helper for the loader
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_ERROR  = 3'd5
    } cfg_state_t;

    localparam logic [7:0] CFG_SYNC_WORD = 8'hA5;

    // Sized in fabric order: brbselect, bsbselect, lbselect, then the four io edges.
    function automatic int cfg_total_bits(input int w, input int h, input int ww, input int lb);
        int brb;
        int bsb;
        int lbs;
        int io;
        brb = (w - 1) * (h - 1) * 4 * ww * 2;
        bsb = 2 * (w + h) * ww * 2;
        lbs = w * h * lb;
        io  = 2 * (w + h) * ww;
        return brb + bsb + lbs + io;
    endfunction

endpackage

// File: rtl/cfg_checksum.sv
// rtl/cfg_checksum.sv - running XOR accumulator over bitstream data beats
module cfg_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ data;
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - word-serial bitstream loader with single-cycle commit; option CFG_LOADER_CHECKSUM_EN
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                CFG_BITS  = 12038,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(CFG_SYNC_WORD)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [CFG_BITS-1:0] cfg_bits,
    output logic                cfg_valid,
    output logic                busy,
    output logic                error
);

    localparam int NUM_BEATS = (CFG_BITS + DATA_W - 1) / DATA_W;
    localparam int SH_BITS   = NUM_BEATS * DATA_W;
    localparam int CNT_W     = $clog2(NUM_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    cfg_state_t        state;
    cfg_state_t        state_d;
    logic [CNT_W-1:0]  beat_cnt;
    logic [SH_BITS-1:0] shadow;
    logic              xfer;
    logic              go_sync;
    logic              sync_ok;
    logic              load_beat;
    logic              set_error;
    logic              do_commit;

    // s_ready depends on state only, so xfer never loops back through s_valid.
    assign s_ready = (state == ST_SYNC) || (state == ST_LOAD) || (state == ST_CHECK);
    assign busy    = (state != ST_IDLE) && (state != ST_ERROR);
    assign xfer    = s_valid & s_ready;

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] chk_acc;

    cfg_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sync_ok),
        .en    (load_beat),
        .data  (s_data),
        .acc   (chk_acc)
    );
`endif

    always_comb begin
        state_d   = state;
        go_sync   = 1'b0;
        sync_ok   = 1'b0;
        load_beat = 1'b0;
        set_error = 1'b0;
        do_commit = 1'b0;
        case (state)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    go_sync = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (xfer) begin
                    if (s_data == SYNC_WORD) begin
                        sync_ok = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        set_error = 1'b1;
                        state_d   = ST_ERROR;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    load_beat = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
`ifdef CFG_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_COMMIT;
`endif
                    end
                end
            end
`ifdef CFG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    if (s_data == chk_acc) begin
                        state_d = ST_COMMIT;
                    end else begin
                        set_error = 1'b1;
                        state_d   = ST_ERROR;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                do_commit = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            cfg_bits  <= '0;
            cfg_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= state_d;
            if (go_sync) begin
                cfg_valid <= 1'b0;
                error     <= 1'b0;
            end
            if (set_error) begin
                error <= 1'b1;
            end
            if (sync_ok) begin
                beat_cnt <= '0;
            end else if (load_beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (do_commit) begin
                cfg_bits  <= shadow[CFG_BITS-1:0];
                cfg_valid <= 1'b1;
            end
        end
    end

    // Shadow is deliberately unreset: every bit is rewritten by a complete load before commit.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            shadow <= {s_data, shadow[SH_BITS-1:DATA_W]};
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard bench for fpga_cfg_loader with a 20-bit image and byte beats
module tb_fpga_cfg_loader;

`ifdef CFG_LOADER_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [19:0] cfg_bits;
    logic        cfg_valid;
    logic        busy;
    logic        error;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          xfers = 0;
    logic [19:0] exp_q[$];
    logic [19:0] expv;
    logic [19:0] last_cfg = 20'h0;

    fpga_cfg_loader #(.DATA_W(8), .CFG_BITS(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .cfg_bits  (cfg_bits),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_valid && s_ready) xfers <= xfers + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input int stall_pct);
        int n;
        while ($urandom_range(0, 99) < stall_pct) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_data  = d;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL beat_accept actual=%b required=1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int stall_pct);
        logic [23:0] img;
        img = {b2, b1, b0};
        exp_q.push_back(img[19:0]);
        send_beat(8'hA5, stall_pct);
        send_beat(b0, stall_pct);
        send_beat(b1, stall_pct);
        send_beat(b2, stall_pct);
`ifdef CFG_LOADER_CHECKSUM_EN
        send_beat(b0 ^ b1 ^ b2, stall_pct);
`endif
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (cfg_valid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (cfg_bits !== 20'h0) begin n_bad++; $display("FAIL reset_cfg_bits actual=%h required=00000", cfg_bits); end
        n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_valid actual=%b required=0", cfg_valid); end
        n_cmp++; if (busy !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL reset_busy_error actual=%b%b required=00", busy, error); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready actual=%b required=0", s_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        int lat;
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || s_ready !== 1'b1) begin n_bad++; $display("FAIL load_sync_state actual=%b%b required=11", busy, s_ready); end
        send_stream(8'h12, 8'h34, 8'hF6, 0);
        n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL load_early_valid actual=%b required=0", cfg_valid); end
        wait_valid(lat);
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL load_latency actual=%0d required=2", lat); end
        expv = exp_q.pop_front();
        n_cmp++; if (cfg_bits !== expv) begin n_bad++; $display("FAIL load_cfg_bits actual=%h required=%h", cfg_bits, expv); end
        n_cmp++; if (error !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL load_flags actual=%b%b required=00", error, busy); end
        last_cfg = expv;
    endtask

    task automatic test_sync_error();
        int lat;
        pulse_start();
        n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL syncerr_valid_cleared actual=%b required=0", cfg_valid); end
        send_beat(8'h5A, 0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL syncerr_error actual=%b required=1", error); end
        n_cmp++; if (s_ready !== 1'b0 || busy !== 1'b0 || cfg_valid !== 1'b0) begin n_bad++; $display("FAIL syncerr_state actual=%b%b%b required=000", s_ready, busy, cfg_valid); end
        n_cmp++; if (cfg_bits !== last_cfg) begin n_bad++; $display("FAIL syncerr_cfg_hold actual=%h required=%h", cfg_bits, last_cfg); end
        pulse_start();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL syncerr_error_clear actual=%b required=0", error); end
        send_stream(8'h11, 8'h22, 8'h33, 0);
        wait_valid(lat);
        expv = exp_q.pop_front();
        n_cmp++; if (cfg_valid !== 1'b1 || cfg_bits !== expv) begin n_bad++; $display("FAIL syncerr_recover actual=%b/%h required=1/%h", cfg_valid, cfg_bits, expv); end
        last_cfg = expv;
    endtask

    task automatic test_stall();
        int lat;
        int x0;
        x0 = xfers;
        pulse_start();
        send_stream(8'h12, 8'h34, 8'hF6, 50);
        wait_valid(lat);
        expv = exp_q.pop_front();
        n_cmp++; if (cfg_valid !== 1'b1 || cfg_bits !== expv) begin n_bad++; $display("FAIL stall_cfg_bits actual=%b/%h required=1/%h", cfg_valid, cfg_bits, expv); end
        n_cmp++; if (xfers - x0 != 4 + EXTRA) begin n_bad++; $display("FAIL stall_transfers actual=%0d required=%0d", xfers - x0, 4 + EXTRA); end
        last_cfg = expv;
    endtask

    task automatic test_reset_midload();
        int lat;
        pulse_start();
        send_beat(8'hA5, 0);
        send_beat(8'h12, 0);
        send_beat(8'h34, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cfg_bits !== 20'h0 || cfg_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs actual=%b/%h required=0/00000", cfg_valid, cfg_bits); end
        n_cmp++; if (busy !== 1'b0 || s_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_idle actual=%b%b required=00", busy, s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_stream(8'h9A, 8'hBC, 8'hDE, 0);
        wait_valid(lat);
        expv = exp_q.pop_front();
        n_cmp++; if (cfg_valid !== 1'b1 || cfg_bits !== expv) begin n_bad++; $display("FAIL midreset_reload actual=%b/%h required=1/%h", cfg_valid, cfg_bits, expv); end
        last_cfg = expv;
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [23:0] img;
        pulse_start();
        send_beat(8'hA5, 0);
        send_beat(8'hAB, 0);
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || s_ready !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL busy_start_state actual=%b%b%b required=110", busy, s_ready, error); end
        img = {8'hEF, 8'hCD, 8'hAB};
        exp_q.push_back(img[19:0]);
        send_beat(8'hCD, 0);
        send_beat(8'hEF, 0);
`ifdef CFG_LOADER_CHECKSUM_EN
        send_beat(8'hAB ^ 8'hCD ^ 8'hEF, 0);
`endif
        wait_valid(lat);
        expv = exp_q.pop_front();
        n_cmp++; if (cfg_valid !== 1'b1 || cfg_bits !== expv) begin n_bad++; $display("FAIL busy_start_commit actual=%b/%h required=1/%h", cfg_valid, cfg_bits, expv); end
        last_cfg = expv;
    endtask

    task automatic test_checksum();
`ifdef CFG_LOADER_CHECKSUM_EN
        int lat;
        pulse_start();
        exp_q.push_back(20'h63412);
        send_beat(8'hA5, 0);
        send_beat(8'h12, 0);
        send_beat(8'h34, 0);
        send_beat(8'hF6, 0);
        send_beat(8'hD0, 0);
        wait_valid(lat);
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL chk_latency actual=%0d required=2", lat); end
        expv = exp_q.pop_front();
        n_cmp++; if (cfg_bits !== expv) begin n_bad++; $display("FAIL chk_good_commit actual=%h required=%h", cfg_bits, expv); end
        last_cfg = expv;
        pulse_start();
        send_beat(8'hA5, 0);
        send_beat(8'h12, 0);
        send_beat(8'h34, 0);
        send_beat(8'hF6, 0);
        send_beat(8'hD1, 0);
        n_cmp++; if (error !== 1'b1 || cfg_valid !== 1'b0) begin n_bad++; $display("FAIL chk_bad_error actual=%b%b required=10", error, cfg_valid); end
        pulse_start();
        send_beat(8'hA5, 0);
        send_beat(8'h55, 0);
        send_beat(8'h66, 0);
        send_beat(8'h77, 0);
        send_beat(8'h45, 0);
        n_cmp++; if (error !== 1'b1 || cfg_bits !== last_cfg) begin n_bad++; $display("FAIL chk_bad_retain actual=%b/%h required=1/%h", error, cfg_bits, last_cfg); end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_sync_error();
        test_stall();
        test_reset_midload();
        test_start_ignored();
        test_checksum();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
